// File: rtl/amm_slave_mem_if.sv
// Avalon-MM bus bundle shared by a master and the on-chip memory slave.
interface avalon_mm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/amm_slave_mem.sv
// Avalon-MM slave backed by a byte-writable memory, with programmable
// command stall, fixed read latency and a cap on outstanding reads.
module amm_slave_mem #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int MEM_ADDR_W  = 10,
  parameter int READ_LAT    = 2,
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_PEND    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  avalon_mm_if.slave amm_if,
  output logic       err_o
);

  localparam int             BE_W       = DATA_W / 8;
  localparam logic [3:0]     WAIT_C     = 4'(WAIT_CYCLES);
  localparam logic [3:0]     MAX_PEND_C = 4'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, STALL, READY} state_t;

  state_t                state, state_nxt;
  logic [3:0]            stall_cnt, stall_cnt_nxt;
  logic [3:0]            pend_cnt;
  logic                  req, can_accept, rd_blocked, wait_req;
  logic                  accept, rd_accept, wr_accept;
  logic [MEM_ADDR_W-1:0] idx;
  logic [DATA_W-1:0]     mem [2**MEM_ADDR_W];
  logic [READ_LAT-1:0]   pipe_v;
  logic [DATA_W-1:0]     pipe_d [READ_LAT];
  logic                  unused_addr;

  // Handshake: a command (read or write high) is taken on the rising edge of
  // any cycle in which waitrequest is low; the master holds it stable until then.
  assign req         = amm_if.read | amm_if.write;
  assign idx         = amm_if.address[MEM_ADDR_W-1:0];
  assign unused_addr = ^amm_if.address[ADDR_W-1:MEM_ADDR_W];

  // With no stall configured an idle slave can take a command immediately.
  assign can_accept  = (state == READY) || (state == IDLE && WAIT_CYCLES == 0);
  // read+write together is handled as a write, so it is never throttled.
  assign rd_blocked  = amm_if.read && !amm_if.write && (pend_cnt == MAX_PEND_C);

  always_comb begin
    wait_req = 1'b0;
    if (rst_i)    wait_req = req;
    else if (req) wait_req = !can_accept || rd_blocked;
  end

  assign amm_if.waitrequest = wait_req;
  assign accept    = req && !wait_req;
  assign rd_accept = accept && amm_if.read && !amm_if.write;
  assign wr_accept = accept && amm_if.write;

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    case (state)
      IDLE: begin
        if (req && !accept) begin
          if (WAIT_C <= 4'd1) begin
            state_nxt     = READY;
            stall_cnt_nxt = WAIT_C;
          end else begin
            state_nxt     = STALL;
            stall_cnt_nxt = 4'd1;
          end
        end
      end
      STALL: begin
        if (!req) begin
          state_nxt     = IDLE;
          stall_cnt_nxt = 4'd0;
        end else begin
          stall_cnt_nxt = stall_cnt + 4'd1;
          if (stall_cnt + 4'd1 == WAIT_C) state_nxt = READY;
        end
      end
      READY: begin
        if (!req || accept) begin
          state_nxt     = IDLE;
          stall_cnt_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        stall_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      stall_cnt <= 4'd0;
      pend_cnt  <= 4'd0;
      err_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      if (rd_accept && !pipe_v[READ_LAT-1])      pend_cnt <= pend_cnt + 4'd1;
      else if (!rd_accept && pipe_v[READ_LAT-1]) pend_cnt <= pend_cnt - 4'd1;
      if (accept && amm_if.read && amm_if.write) err_o <= 1'b1;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < BE_W; b++) begin
        if (amm_if.byteenable[b]) mem[idx][b*8 +: 8] <= amm_if.writedata[b*8 +: 8];
      end
    end
  end

  // Data stages only move with a valid token, so the last stage holds the
  // most recent response between strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd_accept;
      if (rd_accept) pipe_d[0] <= mem[idx];
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign amm_if.readdata      = pipe_d[READ_LAT-1];
  assign amm_if.readdatavalid = pipe_v[READ_LAT-1];

endmodule
